// File: rtl/iob_axistream_in_swreg_def.sv
// Shared software-register definitions for the AXI-Stream input block.
// Latency: constants only, no logic.
// Backpressure: not applicable.
package iob_axistream_in_swreg_def;

    // CPU-visible register byte addresses
    localparam int ADDR_DATA   = 'h0;
    localparam int ADDR_STATUS = 'h4;
    localparam int ADDR_LEVEL  = 'h8;

    // CPU word width is fixed; the packer always builds 32-bit words
    localparam int WORD_W = 32;

    // STATUS field positions (strobe occupies [N:1], last sits at N+1)
    localparam int STATUS_EMPTY_BIT = 0;
    localparam int STATUS_STRB_LSB  = 1;

    // Beat counter covers up to 4 beats per word (TDATA_W = 8)
    localparam int BEAT_CNT_W = 2;

    // Beats per 32-bit word for a given stream width
    function automatic int n_beats(input int tdata_w);
        return WORD_W / tdata_w;
    endfunction

endpackage

// File: rtl/iob_fifo_sync.sv
// Synchronous FIFO with a show-ahead head (r_data is the current head).
// Latency: a push is visible at the head one cycle later; pop takes effect at the edge.
// Backpressure: pushes are dropped while full unless a pop happens in the same cycle.
// Ports: clk, rst (sync, active-high); w_en/w_data/w_full; r_en/r_data/r_empty; level.
module iob_fifo_sync #(
    parameter int W      = 37,
    parameter int ADDR_W = 10
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            w_en,
    input  logic [W-1:0]    w_data,
    output logic            w_full,
    input  logic            r_en,
    output logic [W-1:0]    r_data,
    output logic            r_empty,
    output logic [ADDR_W:0] level
);

    logic [ADDR_W-1:0] wptr;
    logic [ADDR_W-1:0] rptr;
    logic              do_w;
    logic              do_r;

    // level never exceeds 2**ADDR_W, so its top bit alone flags full
    assign w_full  = level[ADDR_W];
    assign r_empty = (level == '0);

    assign do_r = r_en & ~r_empty;
    // A pop in the same cycle frees the slot; the RAM read is combinational,
    // so the head is consumed before the write to the same index commits.
    assign do_w = w_en & (~w_full | do_r);

    iob_ram_2p #(
        .DATA_W (W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk    (clk),
        .w_en   (do_w),
        .w_addr (wptr),
        .w_data (w_data),
        .r_addr (rptr),
        .r_data (r_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (do_w) begin
                wptr <= wptr + 1'b1;
            end
            if (do_r) begin
                rptr <= rptr + 1'b1;
            end
            case ({do_w, do_r})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/iob_ram_2p.sv
// Two-port RAM: one synchronous write port, one asynchronous read port.
// Latency: write lands on the next rising edge; read data is combinational.
// Backpressure: none, caller owns address sequencing.
// Ports: clk; w_en/w_addr/w_data write port; r_addr/r_data read port.
module iob_ram_2p #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              w_en,
    input  logic [ADDR_W-1:0] w_addr,
    input  logic [DATA_W-1:0] w_data,
    input  logic [ADDR_W-1:0] r_addr,
    output logic [DATA_W-1:0] r_data
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (w_en) begin
            mem[w_addr] <= w_data;
        end
    end

    assign r_data = mem[r_addr];

endmodule

// File: rtl/iob_axistream_in.sv
// AXI-Stream receiver: packs beats LSB-first into 32-bit words, queues them, CPU reads them.
// Latency: word enters the FIFO on the completing beat; CPU read data returns one cycle after request.
// Backpressure: tready drops only while a completed word waits for FIFO space.
// Ports: clk, rst (sync, active-high); CPU valid/address/wdata/wstrb -> rdata/rvalid/ready;
//        stream tdata/tvalid/tlast -> tready.
module iob_axistream_in
    import iob_axistream_in_swreg_def::*;
#(
    parameter int TDATA_W         = 8,
    parameter int FIFO_DEPTH_LOG2 = 10,
    parameter int DATA_W          = 32,
    parameter int ADDR_W          = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                valid,
    input  logic [ADDR_W-1:0]   address,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    output logic [DATA_W-1:0]   rdata,
    output logic                rvalid,
    output logic                ready,
    input  logic [TDATA_W-1:0]  tdata,
    input  logic                tvalid,
    output logic                tready,
    input  logic                tlast
);

    localparam int N       = n_beats(TDATA_W);
    localparam int ENTRY_W = WORD_W + N + 1;

    // Packer state
    logic [BEAT_CNT_W-1:0] beat_cnt;
    logic [N-1:0]          strb_acc;
    logic [WORD_W-1:0]     data_acc;
    logic                  pending;
    logic [ENTRY_W-1:0]    pend_entry;

    logic                  accept;
    logic                  word_done;
    logic [WORD_W-1:0]     beat_data;
    logic [N-1:0]          beat_strb;
    logic [ENTRY_W-1:0]    new_entry;

    // FIFO interface
    logic                  push_req;
    logic                  push;
    logic [ENTRY_W-1:0]    push_entry;
    logic                  pop;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [ENTRY_W-1:0]    fifo_head;
    logic [FIFO_DEPTH_LOG2:0] fifo_level;

    // CPU decode
    logic                  cpu_rd;
    logic                  sel_data;
    logic                  sel_status;
    logic                  sel_level;
    logic [DATA_W-1:0]     rd_mux;

    // Write data is accepted but ignored; no register is writable
    logic unused_wdata;
    assign unused_wdata = ^wdata;

    //------------------------------------------------------------------
    // Stream packer
    //------------------------------------------------------------------
    assign tready = ~pending;
    assign accept = tvalid & tready;

    assign beat_data = data_acc | (WORD_W'(tdata) << (32'(beat_cnt) * TDATA_W));
    assign beat_strb = strb_acc | (N'(1) << beat_cnt);
    assign word_done = accept & (tlast | (beat_cnt == BEAT_CNT_W'(N - 1)));
    assign new_entry = {tlast, beat_strb, beat_data};

    // pending and a fresh completion are exclusive: no beat is accepted while pending
    assign push_req   = pending | word_done;
    assign push_entry = pending ? pend_entry : new_entry;
    assign push       = push_req & (~fifo_full | pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt   <= '0;
            strb_acc   <= '0;
            data_acc   <= '0;
            pending    <= 1'b0;
            pend_entry <= '0;
        end else begin
            if (accept) begin
                if (word_done) begin
                    beat_cnt <= '0;
                    strb_acc <= '0;
                    data_acc <= '0;
                end else begin
                    beat_cnt <= beat_cnt + 1'b1;
                    strb_acc <= beat_strb;
                    data_acc <= beat_data;
                end
            end
            // Park a completed word that found the FIFO full; it stalls the stream
            // until a CPU pop frees a slot, then drains in that same cycle.
            if (word_done && !push) begin
                pending    <= 1'b1;
                pend_entry <= new_entry;
            end else if (pending && push) begin
                pending <= 1'b0;
            end
        end
    end

    iob_fifo_sync #(
        .W      (ENTRY_W),
        .ADDR_W (FIFO_DEPTH_LOG2)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .w_en    (push),
        .w_data  (push_entry),
        .w_full  (fifo_full),
        .r_en    (pop),
        .r_data  (fifo_head),
        .r_empty (fifo_empty),
        .level   (fifo_level)
    );

    //------------------------------------------------------------------
    // CPU register interface
    //------------------------------------------------------------------
    assign ready      = valid;
    assign cpu_rd     = valid & (wstrb == '0);
    assign sel_data   = (address == ADDR_W'(ADDR_DATA));
    assign sel_status = (address == ADDR_W'(ADDR_STATUS));
    assign sel_level  = (address == ADDR_W'(ADDR_LEVEL));
    assign pop        = cpu_rd & sel_data & ~fifo_empty;

    always_comb begin
        rd_mux = '0;
        if (cpu_rd) begin
            if (sel_data) begin
                if (!fifo_empty) begin
                    rd_mux = DATA_W'(fifo_head[WORD_W-1:0]);
                end
            end else if (sel_status) begin
                // Head fields are meaningless when empty, so report only the flag
                if (fifo_empty) begin
                    rd_mux = DATA_W'(1) << STATUS_EMPTY_BIT;
                end else begin
                    rd_mux = DATA_W'(fifo_head[ENTRY_W-1:WORD_W]) << STATUS_STRB_LSB;
                end
            end else if (sel_level) begin
                rd_mux = DATA_W'(fifo_level);
            end
        end
    end

    // rd_mux is zero whenever no read is issued, which keeps rdata at 0 outside rvalid
    always_ff @(posedge clk) begin
        if (rst) begin
            rvalid <= 1'b0;
            rdata  <= '0;
        end else begin
            rvalid <= cpu_rd;
            rdata  <= rd_mux;
        end
    end

endmodule

// File: tb/tb_iob_axistream_in.sv
module tb_iob_axistream_in;

    localparam int TDATA_W    = 8;
    localparam int DEPTH_LOG2 = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid = 1'b0;
    logic [3:0]  address = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic [31:0] rdata;
    logic        rvalid;
    logic        ready;
    logic [7:0]  tdata = '0;
    logic        tvalid = 1'b0;
    logic        tready;
    logic        tlast = 1'b0;

    int checks = 0;
    int passed = 0;

    logic [31:0] exp_q[$];
    string       name_q[$];

    iob_axistream_in #(
        .TDATA_W         (TDATA_W),
        .FIFO_DEPTH_LOG2 (DEPTH_LOG2),
        .DATA_W          (32),
        .ADDR_W          (4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .valid   (valid),
        .address (address),
        .wdata   (wdata),
        .wstrb   (wstrb),
        .rdata   (rdata),
        .rvalid  (rvalid),
        .ready   (ready),
        .tdata   (tdata),
        .tvalid  (tvalid),
        .tready  (tready),
        .tlast   (tlast)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue a read; the expected response goes to the scoreboard
    task automatic cpu_read(input logic [3:0] addr, input logic [31:0] exp, input string name);
        valid   = 1'b1;
        address = addr;
        wstrb   = 4'h0;
        exp_q.push_back(exp);
        name_q.push_back(name);
        tick();
        valid = 1'b0;
    endtask

    task automatic cpu_write(input logic [3:0] addr, input logic [31:0] data);
        valid   = 1'b1;
        address = addr;
        wdata   = data;
        wstrb   = 4'hF;
        #1;
        check("ready_on_write", {31'd0, ready}, 32'd1);
        @(posedge clk);
        #1;
        valid = 1'b0;
        wstrb = 4'h0;
    endtask

    task automatic send_beat(input logic [7:0] d, input logic last);
        int n;
        tdata  = d;
        tlast  = last;
        tvalid = 1'b1;
        n = 0;
        while (tready !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) check("tready_timeout", {31'd0, tready}, 32'd1);
        tick();
        tvalid = 1'b0;
        tlast  = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input logic last);
        for (int j = 0; j < 4; j++) send_beat(w[j*8 +: 8], last && (j == 3));
    endtask

    function automatic logic [31:0] mk(input int i);
        logic [7:0] b0, b1, b2, b3;
        b0 = 8'(16 * i + 1);
        b1 = 8'(16 * i + 2);
        b2 = 8'(16 * i + 3);
        b3 = 8'(16 * i + 4);
        return {b3, b2, b1, b0};
    endfunction

    // Scoreboard monitor: compare every read response against the queue head
    always @(negedge clk) begin
        if (rvalid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_rvalid: got rdata 0x%08h, expected no response", rdata);
            end else begin
                check(name_q.pop_front(), rdata, exp_q.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] wa, wb, wc;

        // Reset state
        rst = 1'b1;
        repeat (2) tick();
        check("reset_tready", {31'd0, tready}, 32'd1);
        check("reset_rvalid", {31'd0, rvalid}, 32'd0);
        check("reset_rdata", rdata, 32'd0);
        rst = 1'b0;
        tick();
        cpu_read(4'h8, 32'd0, "reset_level");
        cpu_read(4'h4, 32'h1, "reset_status_empty");

        // Four full beats, tlast on the fourth
        send_beat(8'h11, 1'b0);
        send_beat(8'h22, 1'b0);
        send_beat(8'h33, 1'b0);
        send_beat(8'h44, 1'b1);
        cpu_read(4'h4, 32'h0000_003E, "full_word_status");
        cpu_read(4'h0, 32'h4433_2211, "full_word_data");
        cpu_read(4'h8, 32'd0, "full_word_level_after");

        // Short packet: two beats
        send_beat(8'hAA, 1'b0);
        send_beat(8'hBB, 1'b1);
        cpu_read(4'h4, 32'h0000_0026, "short_status");
        cpu_read(4'h0, 32'h0000_BBAA, "short_data");

        // tlast on beat 0
        send_beat(8'h5C, 1'b1);
        cpu_read(4'h4, 32'h0000_0022, "beat0_last_status");
        cpu_read(4'h0, 32'h0000_005C, "beat0_last_data");

        // Empty read and ignored writes
        cpu_read(4'h0, 32'd0, "empty_data_read");
        cpu_read(4'h8, 32'd0, "empty_level");
        send_word(32'hCAFE_F00D, 1'b1);
        cpu_write(4'h0, 32'h1234_5678);
        cpu_write(4'h8, 32'hFFFF_FFFF);
        cpu_read(4'h8, 32'd1, "level_after_writes");
        cpu_read(4'hC, 32'd0, "unmapped_read");
        cpu_read(4'h0, 32'hCAFE_F00D, "data_after_writes");

        // Overfill a depth-4 FIFO: fifth word parks in pending
        for (int i = 0; i < 5; i++) send_word(mk(i), 1'b0);
        check("tready_low_when_pending", {31'd0, tready}, 32'd0);
        cpu_read(4'h8, 32'd4, "level_full");
        check("tready_still_low", {31'd0, tready}, 32'd0);
        cpu_read(4'h0, mk(0), "overfill_word0");
        check("tready_back_after_pop", {31'd0, tready}, 32'd1);
        cpu_read(4'h8, 32'd4, "level_refilled");
        for (int i = 1; i < 5; i++) cpu_read(4'h0, mk(i), "overfill_word_in_order");
        cpu_read(4'h8, 32'd0, "level_drained");

        // Pop and completion in the same cycle with two words queued
        wa = 32'hA4A3_A2A1;
        wb = 32'hB4B3_B2B1;
        wc = 32'hC4C3_C2C1;
        send_word(wa, 1'b0);
        send_word(wb, 1'b0);
        send_beat(wc[7:0], 1'b0);
        send_beat(wc[15:8], 1'b0);
        send_beat(wc[23:16], 1'b0);
        check("tready_before_concurrent", {31'd0, tready}, 32'd1);
        tdata   = wc[31:24];
        tvalid  = 1'b1;
        tlast   = 1'b0;
        valid   = 1'b1;
        address = 4'h0;
        wstrb   = 4'h0;
        exp_q.push_back(wa);
        name_q.push_back("concurrent_pop_data");
        tick();
        tvalid = 1'b0;
        valid  = 1'b0;
        cpu_read(4'h8, 32'd2, "concurrent_level");
        cpu_read(4'h0, wb, "concurrent_order_b");
        cpu_read(4'h0, wc, "concurrent_order_c");

        // Reset mid-packet discards the partial word and queued data
        send_word(32'h7777_7777, 1'b1);
        send_beat(8'hE1, 1'b0);
        send_beat(8'hE2, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("tready_after_reset", {31'd0, tready}, 32'd1);
        cpu_read(4'h8, 32'd0, "level_after_reset");
        send_beat(8'h01, 1'b0);
        send_beat(8'h02, 1'b0);
        send_beat(8'h03, 1'b0);
        send_beat(8'h04, 1'b0);
        cpu_read(4'h0, 32'h0403_0201, "post_reset_word");

        repeat (3) tick();
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
